// File: rtl/alu_pkg.sv
// Shared decode constants, the decoded-control struct and skid-buffer state type
// for the ALU control stage.
package alu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SUBI  = 4'b0101;
  localparam logic [3:0] OP_ANDI  = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_SLTI  = 4'b1000;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_SW    = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_XOR = 3'b010;
  localparam logic [2:0] FN_ADD = 3'b011;
  localparam logic [2:0] FN_SUB = 3'b100;
  localparam logic [2:0] FN_SLT = 3'b101;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_SLTI = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       binvert;
    logic       carry_in;
    logic       use_imm;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Subtract-like operations share the inverted-B, carry-in-1 slice setup.
  function automatic ctrl_t mk_ctrl(input logic [2:0] code, input logic sub,
                                    input logic imm, input logic wr,
                                    input logic ill);
    ctrl_t c;
    c.alu_ctrl  = code;
    c.binvert   = sub;
    c.carry_in  = sub;
    c.use_imm   = imm;
    c.reg_write = wr;
    c.illegal   = ill;
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder producing the ALU slice controls.
// Unknown encodings decode to an AND bubble with writeback disabled.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1);
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b1, 1'b0);
          FN_OR:   ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b1, 1'b0);
          FN_XOR:  ctrl = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
          FN_ADD:  ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
          FN_SUB:  ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
          FN_SLT:  ctrl = mk_ctrl(ALU_SLT, 1'b1, 1'b0, 1'b1, 1'b0);
          default: ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1);
        endcase
      end
      OP_ADDI: ctrl = mk_ctrl(ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b0);
      OP_SUBI: ctrl = mk_ctrl(ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b0);
      OP_ANDI: ctrl = mk_ctrl(ALU_AND,  1'b0, 1'b1, 1'b1, 1'b0);
      OP_ORI:  ctrl = mk_ctrl(ALU_OR,   1'b0, 1'b1, 1'b1, 1'b0);
      OP_SLTI: ctrl = mk_ctrl(ALU_SLTI, 1'b1, 1'b1, 1'b1, 1'b0);
      OP_LW:   ctrl = mk_ctrl(ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b0);
      OP_SW:   ctrl = mk_ctrl(ALU_ADD,  1'b0, 1'b1, 1'b0, 1'b0);
      OP_BEQ:  ctrl = mk_ctrl(ALU_ADD,  1'b1, 1'b0, 1'b0, 1'b0);
      default: ctrl = mk_ctrl(ALU_AND,  1'b0, 1'b0, 1'b0, 1'b1);
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX stage: decodes ALU controls and registers them with operands behind a
// 2-entry skid buffer. Optional Illegal output under ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [3:0]    Opcode,
  input  logic [2:0]    Funct,
  input  logic [5:0]    Imm6,
  input  logic [DW-1:0] RsVal,
  input  logic [DW-1:0] RtVal,
  input  logic [2:0]    RdIn,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [2:0]    AluCtrl,
  output logic          Binvert,
  output logic          CarryIn,
  output logic [DW-1:0] OpA,
  output logic [DW-1:0] OpB,
  output logic [2:0]    RdOut,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  output logic          Illegal,
`endif
  output logic          RegWrite
);

  typedef struct packed {
    logic [2:0]    alu_ctrl;
    logic          binvert;
    logic          carry_in;
    logic          reg_write;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic          illegal;
`endif
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [2:0]    rd;
  } entry_t;

  ctrl_t       ctrl;
  entry_t      in_entry;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  skid_state_e state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, consume;

  alu_ctrl_decode u_decode (
    .opcode (Opcode),
    .funct  (Funct),
    .ctrl   (ctrl)
  );

  always_comb begin
    in_entry           = '0;
    in_entry.alu_ctrl  = ctrl.alu_ctrl;
    in_entry.binvert   = ctrl.binvert;
    in_entry.carry_in  = ctrl.carry_in;
    in_entry.reg_write = ctrl.reg_write & ~ctrl.illegal;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    in_entry.illegal   = ctrl.illegal;
`endif
    in_entry.opa       = RsVal;
    in_entry.opb       = ctrl.use_imm ? {{(DW-6){Imm6[5]}}, Imm6} : RtVal;
    in_entry.rd        = RdIn;
  end

  assign accept  = InValid & in_ready_q;
  assign consume = out_valid_q & OutReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_d = ST_TWO;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so InReady never
  // depends combinationally on OutReady.
  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
    if (!Flush) begin
      case (state_q)
        ST_EMPTY: if (accept) out_d = in_entry;
        ST_ONE: begin
          if (accept && consume)       out_d  = in_entry;
          else if (accept && !consume) skid_d = in_entry;
        end
        ST_TWO:   if (consume) out_d = skid_q;
        default:  ;
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign AluCtrl  = out_q.alu_ctrl;
  assign Binvert  = out_q.binvert;
  assign CarryIn  = out_q.carry_in;
  assign OpA      = out_q.opa;
  assign OpB      = out_q.opb;
  assign RdOut    = out_q.rd;
  assign RegWrite = out_q.reg_write;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign Illegal  = out_q.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: a queue-based occupancy/decode model is
// updated at each clock edge and a negedge monitor checks every DUT output.
module tb_alu_ctrl_stage;

  typedef struct {
    logic [2:0]  ac;
    logic        bi;
    logic        ci;
    logic        rw;
    logic        legal;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic        InReady, OutValid;
  logic [3:0]  Opcode;
  logic [2:0]  Funct, RdIn;
  logic [5:0]  Imm6;
  logic [15:0] RsVal, RtVal;
  logic [2:0]  AluCtrl, RdOut;
  logic        Binvert, CarryIn, RegWrite;
  logic [15:0] OpA, OpB;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t q[$];
  bit   started  = 0;
  bit   zero_exp = 0;

  alu_ctrl_stage #(.DW(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .Imm6     (Imm6),
    .RsVal    (RsVal),
    .RtVal    (RtVal),
    .RdIn     (RdIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .AluCtrl  (AluCtrl),
    .Binvert  (Binvert),
    .CarryIn  (CarryIn),
    .OpA      (OpA),
    .OpB      (OpB),
    .RdOut    (RdOut),
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    .Illegal  (Illegal),
`endif
    .RegWrite (RegWrite)
  );

  always #5 Clock = ~Clock;

  // Reference: classify the instruction by mnemonic, then derive controls.
  function automatic exp_t model(logic [3:0] op, logic [2:0] fn, logic [5:0] imm,
                                 logic [15:0] rs, logic [15:0] rt, logic [2:0] rd);
    exp_t  e;
    string mn = "BUBBLE";
    bit    use_imm = 1;
    bit    wr = 1;
    int    v;
    if (op == 4'd0) begin
      use_imm = 0;
      case (fn)
        3'd0: mn = "AND";
        3'd1: mn = "OR";
        3'd2: mn = "XOR";
        3'd3: mn = "ADD";
        3'd4: mn = "SUB";
        3'd5: mn = "SLT";
        default: mn = "BUBBLE";
      endcase
    end else begin
      case (op)
        4'd4:  mn = "ADD";
        4'd5:  mn = "SUB";
        4'd6:  mn = "AND";
        4'd7:  mn = "OR";
        4'd8:  mn = "SLTI";
        4'd9:  mn = "ADD";
        4'd10: begin mn = "ADD"; wr = 0; end
        4'd11: begin mn = "SUB"; wr = 0; use_imm = 0; end
        default: mn = "BUBBLE";
      endcase
    end
    e.legal = (mn != "BUBBLE");
    if (!e.legal) begin
      wr = 0;
      use_imm = 0;
    end
    if (mn == "OR")                        e.ac = 3'd2;
    else if (mn == "XOR")                  e.ac = 3'd3;
    else if (mn == "ADD" || mn == "SUB")   e.ac = 3'd4;
    else if (mn == "SLT")                  e.ac = 3'd6;
    else if (mn == "SLTI")                 e.ac = 3'd1;
    else                                   e.ac = 3'd0;
    e.bi = (mn == "SUB" || mn == "SLT" || mn == "SLTI");
    e.ci = e.bi;
    e.rw = wr;
    v = int'(imm);
    if (v > 31) v = v - 64;
    e.a  = rs;
    e.b  = use_imm ? 16'(v) : rt;
    e.rd = rd;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update at the active edge, using the model's own occupancy for ready.
  always @(posedge Clock) begin
    int n;
    if (Reset) begin
      q.delete();
      zero_exp = 1;
      started  = 1;
    end else if (Flush) begin
      q.delete();
    end else begin
      n = q.size();
      if (n > 0 && OutReady) void'(q.pop_front());
      if (InValid && n < 2) begin
        q.push_back(model(Opcode, Funct, Imm6, RsVal, RtVal, RdIn));
        zero_exp = 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      chk("OutValid", 32'(OutValid), 32'(q.size() != 0));
      chk("InReady",  32'(InReady),  32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("AluCtrl",  32'(AluCtrl),  32'(q[0].ac));
        chk("Binvert",  32'(Binvert),  32'(q[0].bi));
        chk("CarryIn",  32'(CarryIn),  32'(q[0].ci));
        chk("OpA",      32'(OpA),      32'(q[0].a));
        chk("RdOut",    32'(RdOut),    32'(q[0].rd));
        chk("RegWrite", 32'(RegWrite), 32'(q[0].rw));
        if (q[0].legal) chk("OpB", 32'(OpB), 32'(q[0].b));
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        chk("Illegal",  32'(Illegal),  32'(!q[0].legal));
`endif
      end else if (zero_exp) begin
        chk("rst_AluCtrl",  32'(AluCtrl),  32'd0);
        chk("rst_Binvert",  32'(Binvert),  32'd0);
        chk("rst_CarryIn",  32'(CarryIn),  32'd0);
        chk("rst_OpA",      32'(OpA),      32'd0);
        chk("rst_OpB",      32'(OpB),      32'd0);
        chk("rst_RdOut",    32'(RdOut),    32'd0);
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        chk("rst_Illegal",  32'(Illegal),  32'd0);
`endif
      end
    end
  end

  task automatic step(bit iv, bit ordy, bit fl, bit rst, logic [3:0] op,
                      logic [2:0] fn, logic [5:0] imm, logic [15:0] rs,
                      logic [15:0] rt);
    InValid  = iv;
    OutReady = ordy;
    Flush    = fl;
    Reset    = rst;
    Opcode   = op;
    Funct    = fn;
    Imm6     = imm;
    RsVal    = rs;
    RtVal    = rt;
    RdIn     = 3'($urandom);
    @(negedge Clock);
  endtask

  task automatic rstep(bit iv, bit ordy, bit fl, bit rst);
    step(iv, ordy, fl, rst, 4'($urandom_range(0, 11)), 3'($urandom_range(0, 5)),
         6'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    Reset = 1; Flush = 0; InValid = 0; OutReady = 0;
    Opcode = '0; Funct = '0; Imm6 = '0; RsVal = '0; RtVal = '0; RdIn = '0;
    repeat (2) @(negedge Clock);

    step(1, 1, 0, 0, 4'b0000, 3'b100, 6'h00, 16'h0009, 16'h0003);
    step(1, 1, 0, 0, 4'b1000, 3'b000, 6'h3F, 16'h1234, 16'h5678);
    step(0, 1, 0, 0, 4'b0000, 3'b000, 6'h00, 16'h0000, 16'h0000);

    repeat (3) rstep(1, 0, 0, 0);
    repeat (2) rstep(0, 0, 0, 0);
    repeat (3) rstep(0, 1, 0, 0);

    repeat (2) rstep(1, 0, 0, 0);
    rstep(1, 0, 1, 0);
    repeat (2) rstep(0, 1, 0, 0);

    step(1, 1, 0, 0, 4'b1111, 3'b000, 6'h15, 16'hAAAA, 16'h5555);
    step(1, 1, 0, 0, 4'b0000, 3'b110, 6'h2A, 16'h0F0F, 16'hF0F0);
    step(0, 1, 0, 0, 4'b0000, 3'b000, 6'h00, 16'h0000, 16'h0000);

    repeat (2) rstep(1, 0, 0, 0);
    rstep(0, 0, 0, 1);
    repeat (2) rstep(0, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
           4'($urandom), 3'($urandom), 6'($urandom), 16'($urandom), 16'($urandom));
    end
    repeat (4) rstep(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
